// File: rtl/alu_pkg.sv
// Shared ALU operation encodings, decode-stage ALUOp classes and funct3 constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND     = 4'b0000,
        OP_OR      = 4'b0001,
        OP_ADD     = 4'b0010,
        OP_SUB     = 4'b0011,
        OP_XOR     = 4'b0100,
        OP_SLL     = 4'b0101,
        OP_EQ      = 4'b1000,
        OP_ILLEGAL = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

endpackage

// File: rtl/alu_op_issue_if.sv
// Decode-to-execute ALU operation handshake bundle (request side and issue side).
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready valid-ready pairs.
// master = the issuing block; slave = decode stage plus execute stage around it.
interface alu_op_issue_if #(
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 5
);
    // decode-stage request
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_aluop;
    logic [2:0]               in_funct3;
    logic                     in_funct7b5;
    logic [TAG_WIDTH-1:0]     in_tag;
    // execute-stage issue
    logic                     out_valid;
    logic                     out_ready;
    logic [OPCODE_LENGTH-1:0] out_op;
    logic                     out_illegal;
    logic [TAG_WIDTH-1:0]     out_tag;

    modport master (
        input  in_valid, in_aluop, in_funct3, in_funct7b5, in_tag, out_ready,
        output in_ready, out_valid, out_op, out_illegal, out_tag
    );

    modport slave (
        output in_valid, in_aluop, in_funct3, in_funct7b5, in_tag, out_ready,
        input  in_ready, out_valid, out_op, out_illegal, out_tag
    );
endinterface

// File: rtl/alu_op_lut.sv
// Translates ALUOp/funct3/funct7[5] into an ALU operation code plus illegal flag.
// Latency: combinational.
// Backpressure: none.
// Ports: aluop_i, funct3_i, funct7b5_i in; op_o, illegal_o out.
module alu_op_lut
    import alu_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output alu_op_e    op_o,
    output logic       illegal_o
);

    always_comb begin
        op_o = OP_ILLEGAL;
        case (aluop_e'(aluop_i))
            ALUOP_MEM: op_o = OP_ADD;
            ALUOP_BRANCH: begin
                if (funct3_i == F3_BEQ) op_o = OP_EQ;
            end
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (funct3_i)
                    // funct7[5] selects SUB only for register-register forms;
                    // for immediates bit 30 is part of the immediate.
                    F3_ADD: op_o = (aluop_i == ALUOP_RTYPE && funct7b5_i) ? OP_SUB : OP_ADD;
                    F3_AND: op_o = OP_AND;
                    F3_OR:  op_o = OP_OR;
                    F3_XOR: op_o = OP_XOR;
                    F3_SLL: if (!funct7b5_i) op_o = OP_SLL;
                    default: op_o = OP_ILLEGAL;
                endcase
            end
            default: op_o = OP_ILLEGAL;
        endcase
    end

    assign illegal_o = (op_o == OP_ILLEGAL);

endmodule

// File: rtl/alu_op_issue.sv
// Registers decoded ALU operations toward execute through a main stage plus one skid entry.
// Latency: 1 cycle accept-to-valid; 1 op/cycle when out_ready stays high.
// Backpressure: in_ready is a flop (= skid empty), never a combinational function of out_ready.
// Ports: clk, rst_n, flush, illegal_cnt plain; request/issue handshakes via bus (master).
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int OPCODE_LENGTH = ALU_OP_W,
    parameter int TAG_WIDTH     = 5,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] illegal_cnt,
    alu_op_issue_if.master       bus
);

    alu_op_e                  dec_op;
    logic                     dec_illegal;

    logic                     main_vld_q, main_vld_d;
    logic [OPCODE_LENGTH-1:0] main_op_q, main_op_d;
    logic                     main_ill_q, main_ill_d;
    logic [TAG_WIDTH-1:0]     main_tag_q, main_tag_d;

    logic                     skid_vld_q, skid_vld_d;
    logic [OPCODE_LENGTH-1:0] skid_op_q, skid_op_d;
    logic                     skid_ill_q, skid_ill_d;
    logic [TAG_WIDTH-1:0]     skid_tag_q, skid_tag_d;

    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

    logic                     accept;
    logic                     fire;
    logic                     main_free;

    alu_op_lut u_lut (
        .aluop_i    (bus.in_aluop),
        .funct3_i   (bus.in_funct3),
        .funct7b5_i (bus.in_funct7b5),
        .op_o       (dec_op),
        .illegal_o  (dec_illegal)
    );

    assign accept    = bus.in_valid && !skid_vld_q && !flush;
    assign fire      = main_vld_q && bus.out_ready;
    assign main_free = !main_vld_q || fire;

    always_comb begin
        main_vld_d = main_vld_q;
        main_op_d  = main_op_q;
        main_ill_d = main_ill_q;
        main_tag_d = main_tag_q;
        skid_vld_d = skid_vld_q;
        skid_op_d  = skid_op_q;
        skid_ill_d = skid_ill_q;
        skid_tag_d = skid_tag_q;
        cnt_d      = cnt_q;

        // Skid always drains first; while it is full in_ready is low, so an
        // accept can never coincide with a skid-to-main move.
        if (main_free) begin
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_op_d  = skid_op_q;
                main_ill_d = skid_ill_q;
                main_tag_d = skid_tag_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_vld_d = 1'b1;
                main_op_d  = dec_op;
                main_ill_d = dec_illegal;
                main_tag_d = bus.in_tag;
            end else begin
                main_vld_d = 1'b0;
            end
        end

        if (accept && main_vld_q && !fire) begin
            skid_vld_d = 1'b1;
            skid_op_d  = dec_op;
            skid_ill_d = dec_illegal;
            skid_tag_d = bus.in_tag;
        end

        if (accept && dec_illegal && (cnt_q != {CNT_WIDTH{1'b1}}))
            cnt_d = cnt_q + CNT_WIDTH'(1);

        // Flush kills valids only; payload registers may keep stale data.
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q <= 1'b0;
            main_op_q  <= '0;
            main_ill_q <= 1'b0;
            main_tag_q <= '0;
            skid_vld_q <= 1'b0;
            skid_op_q  <= '0;
            skid_ill_q <= 1'b0;
            skid_tag_q <= '0;
            cnt_q      <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            main_op_q  <= main_op_d;
            main_ill_q <= main_ill_d;
            main_tag_q <= main_tag_d;
            skid_vld_q <= skid_vld_d;
            skid_op_q  <= skid_op_d;
            skid_ill_q <= skid_ill_d;
            skid_tag_q <= skid_tag_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready    = !skid_vld_q;
    assign bus.out_valid   = main_vld_q;
    assign bus.out_op      = main_op_q;
    assign bus.out_illegal = main_ill_q;
    assign bus.out_tag     = main_tag_q;
    assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: reset, streaming, backpressure, illegal, flush, async reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: out_ready driven directly by the stimulus.
module tb_alu_op_issue;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [7:0] illegal_cnt;
    int         n_tests;
    int         n_fail;

    alu_op_issue_if #(.OPCODE_LENGTH(4), .TAG_WIDTH(5)) bus ();

    alu_op_issue #(.OPCODE_LENGTH(4), .TAG_WIDTH(5), .CNT_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .illegal_cnt (illegal_cnt),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] aluop, input logic [2:0] f3,
                         input logic f7, input logic [4:0] tag);
        bus.in_valid    = 1'b1;
        bus.in_aluop    = aluop;
        bus.in_funct3   = f3;
        bus.in_funct7b5 = f7;
        bus.in_tag      = tag;
    endtask

    task automatic expect_out(input string name, input logic [3:0] op, input logic [4:0] tag);
        chk({name, "_vld"}, bus.out_valid, 1);
        chk({name, "_op"},  bus.out_op,    op);
        chk({name, "_tag"}, bus.out_tag,   tag);
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_aluop    = 2'b00;
        bus.in_funct3   = 3'b000;
        bus.in_funct7b5 = 1'b0;
        bus.in_tag      = 5'd0;
        bus.out_ready   = 1'b1;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_vld",   bus.out_valid,   0);
        chk("rst_rdy",   bus.in_ready,    1);
        chk("rst_cnt",   illegal_cnt,     0);
        chk("rst_op",    bus.out_op,      0);
        chk("rst_ill",   bus.out_illegal, 0);
        chk("rst_tag",   bus.out_tag,     0);

        // streaming, out_ready=1
        step();
        drive(2'b10, 3'b000, 1'b1, 5'd3);
        step();
        expect_out("s_sub", 4'b0011, 5'd3);
        chk("s_sub_ill", bus.out_illegal, 0);
        drive(2'b11, 3'b100, 1'b0, 5'd4);
        step();
        expect_out("s_xor", 4'b0100, 5'd4);
        drive(2'b01, 3'b000, 1'b0, 5'd5);
        step();
        expect_out("s_eq", 4'b1000, 5'd5);
        bus.in_valid = 1'b0;
        step();
        chk("s_drain_vld", bus.out_valid, 0);

        // backpressure
        bus.out_ready = 1'b0;
        drive(2'b00, 3'b101, 1'b1, 5'd1);
        step();
        expect_out("bp_r1", 4'b0010, 5'd1);
        chk("bp_rdy1", bus.in_ready, 1);
        drive(2'b11, 3'b111, 1'b0, 5'd2);
        step();
        expect_out("bp_hold1", 4'b0010, 5'd1);
        chk("bp_rdy_skid", bus.in_ready, 0);
        drive(2'b11, 3'b110, 1'b0, 5'd3);
        step();
        expect_out("bp_hold2", 4'b0010, 5'd1);
        chk("bp_rdy_still", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        step();
        expect_out("bp_r2", 4'b0000, 5'd2);
        chk("bp_rdy_back", bus.in_ready, 1);
        step();
        expect_out("bp_r3", 4'b0001, 5'd3);
        bus.in_valid = 1'b0;
        step();
        chk("bp_drain_vld", bus.out_valid, 0);

        // illegal encoding and saturation
        drive(2'b10, 3'b001, 1'b1, 5'd7);
        step();
        expect_out("ill", 4'b1111, 5'd7);
        chk("ill_flag", bus.out_illegal, 1);
        chk("ill_cnt1", illegal_cnt, 1);
        drive(2'b01, 3'b001, 1'b0, 5'd8);
        step();
        chk("ill_br_flag", bus.out_illegal, 1);
        chk("ill_cnt2", illegal_cnt, 2);
        repeat (298) step();
        bus.in_valid = 1'b0;
        step();
        chk("ill_sat", illegal_cnt, 255);

        // async reset mid-cycle
        bus.out_ready = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 5'd9);
        step();
        chk("ar_pre_vld", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld_drop", bus.out_valid, 0);
        chk("ar_cnt_clr",  illegal_cnt,   0);
        chk("ar_rdy",      bus.in_ready,  1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        drive(2'b10, 3'b100, 1'b0, 5'd10);
        step();
        expect_out("ar_first", 4'b0100, 5'd10);
        bus.in_valid = 1'b0;
        step();

        // flush with main and skid occupied
        bus.out_ready = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 5'd1);
        step();
        drive(2'b00, 3'b000, 1'b0, 5'd2);
        step();
        chk("fl_full_rdy", bus.in_ready, 0);
        drive(2'b10, 3'b001, 1'b1, 5'd31);
        flush = 1'b1;
        step();
        chk("fl1_vld", bus.out_valid, 0);
        chk("fl1_rdy", bus.in_ready,  1);
        chk("fl1_cnt", illegal_cnt,   0);
        // flush while in_ready=1: illegal request must be dropped, not counted
        drive(2'b10, 3'b001, 1'b1, 5'd30);
        step();
        chk("fl2_vld", bus.out_valid, 0);
        chk("fl2_cnt", illegal_cnt,   0);
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("fl_no_emit", bus.out_valid, 0);
        drive(2'b11, 3'b001, 1'b0, 5'd12);
        step();
        expect_out("fl_after", 4'b0101, 5'd12);
        chk("fl_after_cnt", illegal_cnt, 0);
        bus.in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
